// File: rtl/ps2_multikey_decoder.sv
// ps2_multikey_decoder
// PS/2 keyboard front end for the TankWar input path. kclk/kdata are
// oversampled on clk_50m (never used as a clock), each 11-bit frame is
// checked, E0/F0 prefixes are folded into the following code, and a held-state
// bit is kept per mapped key so simultaneous presses (move + fire) coexist.
//
// Ports:
//   clk_50m      in   system clock
//   rst_n        in   asynchronous active-low reset, synchronous release
//   kclk, kdata  in   raw PS/2 lines, asynchronous to clk_50m
//   player_btns  out  held key state, one bit per KEYMAP entry
//   scan_valid   out  one-cycle pulse per decoded non-prefix code
//   scan_code    out  last decoded code byte (held between pulses)
//   scan_ext     out  code was preceded by E0
//   scan_break   out  code was preceded by F0
//   frame_err    out  one-cycle pulse on start/stop/parity error or timeout
//
// Receiver states:
//   state    | meaning
//   S_IDLE   | bus idle, waiting for the start-bit falling edge
//   S_RECV   | shifting bits 1..10 in, inter-edge timeout running
//   S_CHECK  | validate start, stop and odd parity
//   S_DECODE | apply prefix flags / key map for the received byte
module ps2_multikey_decoder #(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned FILTER_LEN      = 8,
  parameter int unsigned TIMEOUT_US      = 2000,
  parameter int unsigned NUM_PLAYERS     = 2,
  parameter int unsigned KEYS_PER_PLAYER = 5,
  parameter logic [NUM_PLAYERS*KEYS_PER_PLAYER*9-1:0] KEYMAP =
    {9'h070, 9'h074, 9'h06B, 9'h072, 9'h075, 9'h029, 9'h023, 9'h01C, 9'h01B, 9'h01D}
) (
  input  logic                                   clk_50m,
  input  logic                                   rst_n,
  input  logic                                   kclk,
  input  logic                                   kdata,
  output logic [NUM_PLAYERS*KEYS_PER_PLAYER-1:0] player_btns,
  output logic                                   scan_valid,
  output logic [7:0]                             scan_code,
  output logic                                   scan_ext,
  output logic                                   scan_break,
  output logic                                   frame_err
);

  localparam int unsigned NKEYS   = NUM_PLAYERS * KEYS_PER_PLAYER;
  localparam int unsigned TMO_CYC = (CLK_HZ / 1000000) * TIMEOUT_US;
  localparam logic [7:0]  FLT_MAX = 8'(FILTER_LEN - 1);
  localparam logic [31:0] TMO_MAX = 32'(TMO_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK, S_DECODE} state_e;

  logic       kclk_s1_q, kclk_s2_q, kdata_s1_q, kdata_s2_q;
  logic       kclk_f_q, kdata_f_q, kclk_f_prev_q;
  logic [7:0] kclk_cnt_q, kdata_cnt_q;
  logic       kclk_fall;

  // Synchronisers and glitch filters. Everything presets to 1 so a reset
  // looks like an idle bus and cannot fabricate a falling edge.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      kclk_s1_q     <= 1'b1;
      kclk_s2_q     <= 1'b1;
      kdata_s1_q    <= 1'b1;
      kdata_s2_q    <= 1'b1;
      kclk_f_q      <= 1'b1;
      kdata_f_q     <= 1'b1;
      kclk_f_prev_q <= 1'b1;
      kclk_cnt_q    <= '0;
      kdata_cnt_q   <= '0;
    end else begin
      kclk_s1_q     <= kclk;
      kclk_s2_q     <= kclk_s1_q;
      kdata_s1_q    <= kdata;
      kdata_s2_q    <= kdata_s1_q;
      kclk_f_prev_q <= kclk_f_q;
      // The filtered value flips on the FILTER_LEN-th consecutive sample
      // that disagrees with it; any agreeing sample restarts the run.
      if (kclk_s2_q == kclk_f_q) begin
        kclk_cnt_q <= '0;
      end else if (kclk_cnt_q == FLT_MAX) begin
        kclk_f_q   <= kclk_s2_q;
        kclk_cnt_q <= '0;
      end else begin
        kclk_cnt_q <= kclk_cnt_q + 8'd1;
      end
      if (kdata_s2_q == kdata_f_q) begin
        kdata_cnt_q <= '0;
      end else if (kdata_cnt_q == FLT_MAX) begin
        kdata_f_q   <= kdata_s2_q;
        kdata_cnt_q <= '0;
      end else begin
        kdata_cnt_q <= kdata_cnt_q + 8'd1;
      end
    end
  end

  assign kclk_fall = kclk_f_prev_q & ~kclk_f_q;

  state_e           state_q;
  logic [3:0]       bitcnt_q;
  logic [10:0]      shift_q;
  logic [31:0]      tmo_q;
  logic             ext_q, brk_q;
  logic [NKEYS-1:0] btns_q;
  logic             scan_valid_q, scan_ext_q, scan_break_q, frame_err_q;
  logic [7:0]       scan_code_q;

  logic [7:0]       rx_byte;
  logic             frame_ok;
  logic [NKEYS-1:0] key_hit;
  logic [NKEYS-1:0] btns_d;

  // Frame layout after 11 LSB-first shifts: [0] start, [8:1] data,
  // [9] parity, [10] stop.
  assign rx_byte  = shift_q[8:1];
  assign frame_ok = ~shift_q[0] & shift_q[10] & (^shift_q[9:1]);

  always_comb begin
    key_hit = '0;
    for (int k = 0; k < int'(NKEYS); k++) begin
      key_hit[k] = (KEYMAP[k*9 +: 9] == {ext_q, rx_byte});
    end
    btns_d = (btns_q & ~key_hit) | (key_hit & {NKEYS{~brk_q}});
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      tmo_q        <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      btns_q       <= '0;
      scan_valid_q <= 1'b0;
      scan_code_q  <= '0;
      scan_ext_q   <= 1'b0;
      scan_break_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (kclk_fall) begin
            shift_q  <= {kdata_f_q, shift_q[10:1]};
            bitcnt_q <= 4'd1;
            tmo_q    <= '0;
            state_q  <= S_RECV;
          end
        end
        S_RECV: begin
          if (kclk_fall) begin
            shift_q <= {kdata_f_q, shift_q[10:1]};
            tmo_q   <= '0;
            if (bitcnt_q == 4'd10) begin
              bitcnt_q <= '0;
              state_q  <= S_CHECK;
            end else begin
              bitcnt_q <= bitcnt_q + 4'd1;
            end
          end else if (tmo_q == TMO_MAX) begin
            frame_err_q <= 1'b1;
            bitcnt_q    <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        S_CHECK: begin
          if (frame_ok) begin
            state_q <= S_DECODE;
          end else begin
            frame_err_q <= 1'b1;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        S_DECODE: begin
          state_q <= S_IDLE;
          case (rx_byte)
            8'hE0: ext_q <= 1'b1;
            8'hF0: brk_q <= 1'b1;
            8'hE1: begin
              ext_q <= 1'b0;
              brk_q <= 1'b0;
            end
            // BAT pass and keyboard error/overrun: the key state can no
            // longer be trusted, so drop every held bit.
            8'hAA, 8'h00, 8'hFF: begin
              btns_q       <= '0;
              scan_valid_q <= 1'b1;
              scan_code_q  <= rx_byte;
              scan_ext_q   <= ext_q;
              scan_break_q <= brk_q;
              ext_q        <= 1'b0;
              brk_q        <= 1'b0;
            end
            default: begin
              btns_q       <= btns_d;
              scan_valid_q <= 1'b1;
              scan_code_q  <= rx_byte;
              scan_ext_q   <= ext_q;
              scan_break_q <= brk_q;
              ext_q        <= 1'b0;
              brk_q        <= 1'b0;
            end
          endcase
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign player_btns = btns_q;
  assign scan_valid  = scan_valid_q;
  assign scan_code   = scan_code_q;
  assign scan_ext    = scan_ext_q;
  assign scan_break  = scan_break_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_multikey_decoder.sv
// Directed bench for ps2_multikey_decoder. Frames are driven on kclk/kdata;
// expected decoder events (code/ext/break, error latency) are queued when a
// frame is sent and checked by a monitor when scan_valid/frame_err pulse.
// Latencies are counted in clk_50m edges from the raw kclk falling edge of
// the last bit sent: 2 sync stages + FILTER_LEN filter + 1 strobe edge.
module tb_ps2_multikey_decoder;

  localparam int FLT    = 8;
  localparam int TC     = 200;          // 1 MHz * 200 us
  localparam int NK     = 10;
  localparam int STROBE = 2 + FLT + 1;  // edge that consumes the strobe
  localparam int LAT_SCAN = STROBE + 2; // CHECK then DECODE
  localparam int LAT_PERR = STROBE + 1; // error raised leaving CHECK
  localparam int LAT_TMO  = STROBE + TC;
  localparam int HALF = 20;
  localparam int GAP  = 40;

  logic          clk_50m = 1'b0;
  logic          rst_n   = 1'b0;
  logic          kclk    = 1'b1;
  logic          kdata   = 1'b1;
  logic [NK-1:0] player_btns;
  logic          scan_valid;
  logic [7:0]    scan_code;
  logic          scan_ext;
  logic          scan_break;
  logic          frame_err;

  ps2_multikey_decoder #(
    .CLK_HZ(1000000), .FILTER_LEN(FLT), .TIMEOUT_US(TC),
    .NUM_PLAYERS(2), .KEYS_PER_PLAYER(5)
  ) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .kclk(kclk), .kdata(kdata),
    .player_btns(player_btns), .scan_valid(scan_valid), .scan_code(scan_code),
    .scan_ext(scan_ext), .scan_break(scan_break), .frame_err(frame_err)
  );

  always #10 clk_50m = ~clk_50m;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } exp_t;

  exp_t scb_q[$];
  int   err_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_fall_cyc = 0;

  always @(posedge clk_50m) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_scan(input logic [7:0] c, input logic e, input logic b);
    exp_t x;
    x.code = c;
    x.ext  = e;
    x.brk  = b;
    scb_q.push_back(x);
  endtask

  // Sends the first nbits bits of a PS/2 frame, device-style: data set while
  // kclk is high, sampled on the falling edge.
  task automatic send(input logic [7:0] b, input bit bad_par = 1'b0, input int nbits = 11);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kdata = fr[i];
      repeat (HALF) @(negedge clk_50m);
      kclk = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk_50m);
      kclk = 1'b1;
    end
    kdata = 1'b1;
    repeat (GAP) @(negedge clk_50m);
  endtask

  // Scoreboard monitor.
  always @(negedge clk_50m) begin
    if (rst_n) begin
      if (scan_valid) begin
        if (scb_q.size() == 0) begin
          chk("scan_unexpected", {24'd0, scan_code}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = scb_q.pop_front();
          chk("scan_code", {24'd0, scan_code}, {24'd0, e.code});
          chk("scan_ext", {31'd0, scan_ext}, {31'd0, e.ext});
          chk("scan_break", {31'd0, scan_break}, {31'd0, e.brk});
          chk("scan_latency", cyc - last_fall_cyc, LAT_SCAN);
        end
      end
      if (frame_err) begin
        if (err_q.size() == 0) begin
          chk("ferr_unexpected", cyc - last_fall_cyc, 32'hFFFF_FFFF);
        end else begin
          chk("ferr_latency", cyc - last_fall_cyc, err_q.pop_front());
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (4) @(negedge clk_50m);
    chk("rst_btns", 32'(player_btns), 32'h0);
    chk("rst_valid", {31'd0, scan_valid}, 32'h0);
    chk("rst_code", {24'd0, scan_code}, 32'h0);
    chk("rst_ferr", {31'd0, frame_err}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_50m);

    // Two makes held together: 1D -> bit0, 29 -> bit4
    expect_scan(8'h1D, 1'b0, 1'b0);
    send(8'h1D);
    chk("btns_make1d", 32'(player_btns), 32'h001);
    expect_scan(8'h29, 1'b0, 1'b0);
    send(8'h29);
    chk("btns_make29", 32'(player_btns), 32'h011);

    // Release 1D only
    send(8'hF0);
    expect_scan(8'h1D, 1'b0, 1'b1);
    send(8'h1D);
    chk("btns_brk1d", 32'(player_btns), 32'h010);

    // Bad parity: error, no scan, no change; next good 75 sets bit5
    err_q.push_back(LAT_PERR);
    send(8'h75, 1'b1);
    chk("btns_badpar", 32'(player_btns), 32'h010);
    expect_scan(8'h75, 1'b0, 1'b0);
    send(8'h75);
    chk("btns_make75", 32'(player_btns), 32'h030);

    // Truncated frame times out; following 72 sets bit6
    err_q.push_back(LAT_TMO);
    send(8'h72, 1'b0, 5);
    repeat (TC + 20) @(negedge clk_50m);
    chk("btns_tmo", 32'(player_btns), 32'h030);
    expect_scan(8'h72, 1'b0, 1'b0);
    send(8'h72);
    chk("btns_make72", 32'(player_btns), 32'h070);

    // Release 75, then extended 75 must not hit the plain-75 entry
    send(8'hF0);
    expect_scan(8'h75, 1'b0, 1'b1);
    send(8'h75);
    chk("btns_brk75", 32'(player_btns), 32'h050);
    send(8'hE0);
    expect_scan(8'h75, 1'b1, 1'b0);
    send(8'h75);
    chk("btns_e075", 32'(player_btns), 32'h050);
    expect_scan(8'h75, 1'b0, 1'b0);
    send(8'h75);
    chk("btns_plain75", 32'(player_btns), 32'h070);
    expect_scan(8'h75, 1'b0, 1'b0);
    send(8'h75);
    chk("btns_typematic", 32'(player_btns), 32'h070);
    send(8'hE0);
    send(8'hF0);
    expect_scan(8'h75, 1'b1, 1'b1);
    send(8'h75);
    chk("btns_e0f075", 32'(player_btns), 32'h070);

    // Three keys held, BAT code clears all
    expect_scan(8'hAA, 1'b0, 1'b0);
    send(8'hAA);
    chk("btns_aa", 32'(player_btns), 32'h000);
    chk("code_held", {24'd0, scan_code}, 32'hAA);

    // Glitches shorter than the filter: 1-cycle and FILTER_LEN-1 cycle lows
    for (int g = 0; g < 3; g++) begin
      kclk = 1'b0;
      @(negedge clk_50m);
      kclk = 1'b1;
      repeat (15) @(negedge clk_50m);
    end
    kclk = 1'b0;
    repeat (FLT - 1) @(negedge clk_50m);
    kclk = 1'b1;
    repeat (TC + 20) @(negedge clk_50m);
    chk("btns_glitch", 32'(player_btns), 32'h000);
    expect_scan(8'h1B, 1'b0, 1'b0);
    send(8'h1B);
    chk("btns_make1b", 32'(player_btns), 32'h002);

    // A frame error drops a pending E0
    send(8'hE0);
    err_q.push_back(LAT_PERR);
    send(8'h12, 1'b1);
    expect_scan(8'h75, 1'b0, 1'b0);
    send(8'h75);
    chk("btns_err_clr_ext", 32'(player_btns), 32'h022);

    // Reset mid-frame discards the partial frame
    send(8'h1C, 1'b0, 4);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_50m);
    chk("btns_midrst", 32'(player_btns), 32'h000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_50m);
    expect_scan(8'h1C, 1'b0, 1'b0);
    send(8'h1C);
    chk("btns_make1c", 32'(player_btns), 32'h004);

    repeat (50) @(negedge clk_50m);
    chk("scan_left", scb_q.size(), 32'h0);
    chk("ferr_left", err_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
